reduce_instr_param: RTL and testbench

- Parametrised successor of the 8-node reduce instruction core. It decodes each reduction packet's algorithm, rank, root and index fields, then computes the children count and destination node for any 2^LgNumProcs-node network.
- Adds a valid/ready handshake with a 2-entry output buffer, deterministic handling of unsupported algorithm codes, and a saturating error counter.
- Sits between the packeter and the reduction-table FIFO inside the router.

---
 rtl/reduce_instr_param.sv | 131 +++++++++++++
 tb/tb_reduce_instr_param.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reduce_instr_param.sv
// Reduction-packet decoder for a 2^LgNumProcs-node network: computes children count and
// destination node, buffered behind a valid/ready handshake with a 2-entry output FIFO.
module reduce_instr_param #(
    parameter int LgNumProcs    = 3,
    parameter int DataWidth     = 64,
    parameter int ChildrenWidth = 3,
    parameter int RankPos       = 37,
    parameter int RootPos       = 40,
    parameter int IndexPos      = 46,
    parameter int AlgtypePos    = 50,
    parameter int DstPos        = 56,
    parameter int ValidBitPos   = 63,
    parameter int ErrCntWidth   = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DataWidth-1:0]               packetIn,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [ChildrenWidth+DataWidth-1:0] packetOut,
    output logic                               alg_err,
    output logic [ErrCntWidth-1:0]             err_count
);

    localparam int L        = LgNumProcs;
    localparam int OutWidth = ChildrenWidth + DataWidth;

    if (ChildrenWidth < $clog2(LgNumProcs + 1) || ValidBitPos >= DataWidth) begin : g_bad_params
        $error("reduce_instr_param: inconsistent field parameters");
    end

    // Children count and rewritten destination for one packet; the valid bit is never filtered.
    function automatic logic [OutWidth-1:0] decode(input logic [DataWidth-1:0] pkt);
        logic [L-1:0]             rank;
        logic [L-1:0]             root;
        logic [L-1:0]             index;
        logic [1:0]               alg;
        logic [L-1:0]             dst;
        logic [ChildrenWidth-1:0] children;
        logic                     found;
        logic [DataWidth-1:0]     body;
        rank     = pkt[RankPos +: L];
        root     = pkt[RootPos +: L];
        index    = pkt[IndexPos +: L];
        alg      = pkt[AlgtypePos +: 2];
        dst      = rank;
        children = '0;
        found    = 1'b0;
        case (alg)
            2'd0: begin
                if (rank == '0) begin
                    children = ChildrenWidth'(L);
                    dst      = root;
                end else begin
                    for (int j = 0; j < L; j++) begin
                        if (!found && rank[j]) begin
                            found    = 1'b1;
                            children = ChildrenWidth'(j);
                            dst[j]   = 1'b0;
                        end
                    end
                end
            end
            2'd1: begin
                children = ChildrenWidth'(L);
                for (int j = 0; j < L; j++) begin
                    if (!found && (rank[j] != index[L-1-j])) begin
                        found    = 1'b1;
                        children = ChildrenWidth'(j);
                        dst[j]   = ~rank[j];
                    end
                end
            end
            default: ;
        endcase
        body              = pkt;
        body[DstPos +: L] = dst;
        return {children, body};
    endfunction

    logic [OutWidth-1:0] dec_p0;
    logic [OutWidth-1:0] entry_p1 [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          count;
    logic                push;
    logic                pop;

    assign dec_p0    = decode(packetIn);
    assign in_ready  = !rst && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign packetOut = out_valid ? entry_p1[rd_ptr] : '0;

    // Stage p0 -> p1: decoded packet captured into the buffer slot
    always_ff @(posedge clk) begin
        if (push) begin
            entry_p1[wr_ptr] <= dec_p0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            alg_err   <= 1'b0;
            err_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            alg_err <= push && packetIn[AlgtypePos+1];
            if (push && packetIn[AlgtypePos+1] && (err_count != '1)) begin
                err_count <= err_count + ErrCntWidth'(1);
            end
        end
    end

endmodule

// File: tb/tb_reduce_instr_param.sv
// Bench for reduce_instr_param: default instance checked every cycle against a queue model,
// plus an LgNumProcs=4 / ErrCntWidth=2 instance exercised with literal expectations.
module tb_reduce_instr_param;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready, alg_err;
    logic [63:0] packet_in;
    logic [66:0] packet_out;
    logic [15:0] err_count;

    logic        in_valid4, in_ready4, out_valid4, out_ready4, alg_err4;
    logic [63:0] packet_in4;
    logic [66:0] packet_out4;
    logic [1:0]  err_count4;

    reduce_instr_param u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .packetIn(packet_in),
        .out_valid(out_valid), .out_ready(out_ready), .packetOut(packet_out),
        .alg_err(alg_err), .err_count(err_count)
    );

    reduce_instr_param #(.LgNumProcs(4), .ErrCntWidth(2)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .packetIn(packet_in4),
        .out_valid(out_valid4), .out_ready(out_ready4), .packetOut(packet_out4),
        .alg_err(alg_err4), .err_count(err_count4)
    );

    int nchk = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Build a packet from field values on top of a background pattern.
    function automatic logic [63:0] mk(input int lg, input int alg, input int rank,
                                       input int root, input int idx, input logic [63:0] base);
        logic [63:0] p;
        p = base;
        for (int i = 0; i < lg; i++) p[40+i] = root[i];
        for (int i = 0; i <= lg; i++) p[46+i] = idx[i];
        for (int i = 0; i < lg; i++) p[37+i] = rank[i];
        p[50] = alg[0];
        p[51] = alg[1];
        return p;
    endfunction

    // Expected {children, packet} from the algorithm rules, using integer arithmetic.
    function automatic logic [66:0] model(input int lg, input logic [63:0] p);
        int rank, root, idx, alg, ch, dst, k;
        logic [63:0] mask, body;
        mask = (64'd1 << lg) - 64'd1;
        rank = int'((p >> 37) & mask);
        root = int'((p >> 40) & mask);
        idx  = int'((p >> 46) & ((64'd1 << (lg + 1)) - 64'd1));
        alg  = int'((p >> 50) & 64'd3);
        ch = 0;
        dst = rank;
        if (alg == 0) begin
            if (rank == 0) begin
                ch = lg;
                dst = root;
            end else begin
                k = 0;
                while (((rank >> k) & 1) == 0) k++;
                ch = k;
                dst = rank - (1 << k);
            end
        end else if (alg == 1) begin
            ch = lg;
            for (int j = lg - 1; j >= 0; j--) begin
                if (((rank >> j) & 1) != ((idx >> (lg - 1 - j)) & 1)) begin
                    ch = j;
                    dst = rank ^ (1 << j);
                end
            end
        end
        body = (p & ~(mask << 56)) | (64'(dst) << 56);
        return {ch[2:0], body};
    endfunction

    logic [66:0] q[$];
    logic        exp_alg_err;
    int          exp_err;
    bit          m_acc, m_pop;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            exp_alg_err = 1'b0;
            exp_err = 0;
        end else begin
            m_acc = in_valid && (q.size() < 2);
            m_pop = (q.size() > 0) && out_ready;
            if (m_pop) void'(q.pop_front());
            if (m_acc) q.push_back(model(3, packet_in));
            exp_alg_err = m_acc && packet_in[51];
            if (m_acc && packet_in[51] && exp_err < 65535) exp_err++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", in_ready, q.size() < 2);
            chk("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) chk("packetOut", packet_out, q[0]);
            chk("alg_err", alg_err, exp_alg_err);
            chk("err_count", err_count, exp_err);
        end
    end

    task automatic send0(input logic [63:0] p);
        in_valid = 1'b1;
        packet_in = p;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send4(input logic [63:0] p);
        in_valid4 = 1'b1;
        packet_in4 = p;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
    endtask

    task automatic expect0(input string name, input int ch, input int dst);
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_children"}, packet_out[66:64], ch[2:0]);
        chk({name, "_dst"}, packet_out[58:56], dst[2:0]);
    endtask

    logic [63:0] pa, pb, pc, px, py;
    logic [66:0] mref;
    logic [63:0] keep;

    initial begin
        keep = ~(64'h7 << 56);
        in_valid = 0; out_ready = 0; packet_in = '0;
        in_valid4 = 0; out_ready4 = 0; packet_in4 = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_packetOut", packet_out, 67'd0);
        chk("rst_alg_err", alg_err, 1'b0);
        chk("rst_err_count", err_count, 16'd0);
        chk("rst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", in_ready, 1'b1);

        mref = model(3, mk(3, 1, 5, 0, 4, 64'd0));
        chk("model_rab_children", mref[66:64], 3'd2);
        chk("model_rab_dst", mref[58:56], 3'd1);
        mref = model(4, mk(4, 0, 12, 0, 0, 64'd0));
        chk("model_bin4_children", mref[66:64], 3'd2);

        out_ready = 1'b1;
        send0(mk(3, 0, 6, 0, 0, {$urandom, $urandom}));  expect0("bin_r6", 1, 4);
        send0(mk(3, 0, 0, 5, 0, {$urandom, $urandom}));  expect0("bin_r0", 3, 5);
        send0(mk(3, 0, 7, 0, 0, {$urandom, $urandom}));  expect0("bin_r7", 0, 6);
        send0(mk(3, 1, 5, 0, 4, {$urandom, $urandom}));  expect0("rab_5_4", 2, 1);
        send0(mk(3, 1, 3, 0, 0, {$urandom, $urandom}));  expect0("rab_3_0", 0, 2);
        send0(mk(3, 1, 0, 0, 0, {$urandom, $urandom}));  expect0("rab_0_0", 3, 0);
        send0(mk(3, 2, 3, 0, 0, {$urandom, $urandom}));  expect0("alg2", 0, 3);
        chk("alg2_err_pulse", alg_err, 1'b1);
        chk("alg2_err_count", err_count, 16'd1);

        // Backpressure: A and B fill the buffer, C waits.
        @(posedge clk); #1;
        out_ready = 1'b0;
        pa = mk(3, 0, 2, 0, 0, {$urandom, $urandom});
        pb = mk(3, 0, 4, 0, 0, {$urandom, $urandom});
        pc = mk(3, 0, 1, 0, 0, {$urandom, $urandom});
        in_valid = 1'b1; packet_in = pa;
        @(posedge clk); #1; packet_in = pb;
        @(posedge clk); #1; packet_in = pc;
        chk("bp_full_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        chk("bp_hold_in_ready", in_ready, 1'b0);
        chk("bp_head_a", packet_out[63:0] & keep, pa & keep);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_head_b", packet_out[63:0] & keep, pb & keep);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_head_c", packet_out[63:0] & keep, pc & keep);
        @(posedge clk); #1;
        chk("bp_drained", out_valid, 1'b0);

        // Asynchronous reset while the buffer is full.
        out_ready = 1'b0;
        px = mk(3, 3, 5, 0, 0, {$urandom, $urandom});
        py = mk(3, 0, 6, 0, 0, {$urandom, $urandom});
        in_valid = 1'b1; packet_in = px;
        @(posedge clk); #1; packet_in = py;
        @(posedge clk); #1; in_valid = 1'b0;
        chk("pre_rst_err_count", err_count, 16'd2);
        chk("pre_rst_in_ready", in_ready, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 1'b0);
        chk("async_rst_err_count", err_count, 16'd0);
        chk("async_rst_packetOut", packet_out, 67'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send0(mk(3, 0, 6, 0, 0, {$urandom, $urandom}));  expect0("post_rst", 1, 4);

        // LgNumProcs=4, ErrCntWidth=2 instance.
        out_ready4 = 1'b1;
        send4(mk(4, 0, 12, 0, 0, {$urandom, $urandom}));
        chk("l4_bin_valid", out_valid4, 1'b1);
        chk("l4_bin_children", packet_out4[66:64], 3'd2);
        chk("l4_bin_dst", packet_out4[59:56], 4'd8);
        send4(mk(4, 1, 0, 0, 0, {$urandom, $urandom}));
        chk("l4_rab_children", packet_out4[66:64], 3'd4);
        chk("l4_rab_dst", packet_out4[59:56], 4'd0);
        in_valid4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            packet_in4 = mk(4, 2, i + 1, 0, 0, {$urandom, $urandom});
            @(posedge clk); #1;
        end
        in_valid4 = 1'b0;
        chk("l4_err_sat", err_count4, 2'd3);
        chk("l4_err_pulse", alg_err4, 1'b1);
        @(posedge clk); #1;
        chk("l4_err_pulse_end", alg_err4, 1'b0);

        // Random traffic on the default instance.
        for (int i = 0; i < 500; i++) begin
            in_valid  = ($urandom % 4) != 0;
            packet_in = {$urandom, $urandom};
            out_ready = ($urandom % 3) != 0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("final_empty", out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end

endmodule
